// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - main control FSM for a multicycle 32-bit MIPS-style datapath
//
// Sequences IR, A/B, ALUOut, PC, register file and the shared memory through
// FETCH / DECODE / execute / writeback states, stalling on mem_ready.
//
// Optional feature macro: MULTICYCLE_CTRL_ADDI_EN (adds ADDI, opcode 6'h08,
// through states ADDIEX=11 and ADDIWB=12; without it 6'h08 is illegal).
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   asynchronous active-high reset
//   opcode[5:0]   in   IR[31:26]
//   mem_ready     in   memory finished the current access this cycle
//   pc_write      out  unconditional PC load
//   pc_write_cond out  PC load qualified by ALU zero
//   i_or_d        out  memory address select (0=PC, 1=ALUOut)
//   mem_read      out  memory read request
//   mem_write     out  memory write request
//   ir_write      out  IR load
//   ab_write      out  A/B operand register load
//   mem_to_reg    out  writeback select (0=ALUOut, 1=MDR)
//   reg_dst       out  destination select (0=rt, 1=rd)
//   reg_write     out  register file write
//   alu_src_a     out  ALU A select (0=PC, 1=A)
//   alu_src_b[1:0] out ALU B select (0=B, 1=4, 2=imm, 3=imm<<2)
//   alu_op[1:0]   out  0=add, 1=sub, 2=funct-decoded
//   pc_source[1:0] out 0=ALU result, 1=ALUOut, 2=jump target
//   illegal_op    out  sticky undefined-opcode flag
//   state_dbg[3:0] out current state encoding

module multicycle_ctrl #(
    parameter logic [5:0] OP_RTYPE = 6'h00,
    parameter logic [5:0] OP_LW    = 6'h23,
    parameter logic [5:0] OP_SW    = 6'h2B,
    parameter logic [5:0] OP_BEQ   = 6'h04,
    parameter logic [5:0] OP_J     = 6'h02
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       ab_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal_op,
    output logic [3:0] state_dbg
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_MEMADR = 4'd3;
    localparam logic [3:0] S_MEMRD  = 4'd4;
    localparam logic [3:0] S_MEMWB  = 4'd5;
    localparam logic [3:0] S_MEMWR  = 4'd6;
    localparam logic [3:0] S_EXEC   = 4'd7;
    localparam logic [3:0] S_ALUWB  = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;
    localparam logic [3:0] S_JUMP   = 4'd10;
`ifdef MULTICYCLE_CTRL_ADDI_EN
    localparam logic [3:0] S_ADDIEX = 4'd11;
    localparam logic [3:0] S_ADDIWB = 4'd12;
    localparam logic [5:0] OP_ADDI  = 6'h08;
`endif

    logic [3:0] state;
    logic [3:0] next_state;
    logic       dec_illegal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            illegal_op <= 1'b0;
        end else begin
            state <= next_state;
            // Sticky until reset: software inspects it after the fact.
            if (state == S_DECODE && dec_illegal) begin
                illegal_op <= 1'b1;
            end
        end
    end

    assign state_dbg = state;

    always_comb begin
        next_state    = S_FETCH;
        dec_illegal   = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        ab_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'd0;
        alu_op        = 2'd0;
        pc_source     = 2'd0;

        case (state)
            S_IDLE: next_state = S_FETCH;
            S_FETCH: begin
                // PC+4 is computed every cycle; IR and PC only commit when
                // the instruction word actually arrives.
                mem_read   = 1'b1;
                alu_src_b  = 2'd1;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                next_state = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Branch target computed speculatively into ALUOut.
                ab_write  = 1'b1;
                alu_src_b = 2'd3;
                case (opcode)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_EXEC;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_J:         next_state = S_JUMP;
`ifdef MULTICYCLE_CTRL_ADDI_EN
                    OP_ADDI:      next_state = S_ADDIEX;
`endif
                    default: begin
                        next_state  = S_FETCH;
                        dec_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'd2;
                next_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_read   = 1'b1;
                i_or_d     = 1'b1;
                next_state = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                next_state = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'd2;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'd1;
                pc_write_cond = 1'b1;
                pc_source     = 2'd1;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'd2;
            end
`ifdef MULTICYCLE_CTRL_ADDI_EN
            S_ADDIEX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'd2;
                next_state = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
            end
`endif
            // Unused encodings: outputs stay 0, recover to FETCH.
            default: next_state = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed self-checking bench for multicycle_ctrl

module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       ab_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       illegal_op;
    logic [3:0] state_dbg;

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .ab_write(ab_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .pc_source(pc_source), .illegal_op(illegal_op),
        .state_dbg(state_dbg)
    );

    // {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, ab_write,
    //  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source}
    wire [16:0] ctl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
                       ir_write, ab_write, mem_to_reg, reg_dst, reg_write,
                       alu_src_a, alu_src_b, alu_op, pc_source};

    localparam logic [16:0] C_ZERO   = 17'b0_0_0_0_0_0_0_0_0_0_0_00_00_00;
    localparam logic [16:0] C_FETCH  = 17'b1_0_0_1_0_1_0_0_0_0_0_01_00_00;
    localparam logic [16:0] C_FSTALL = 17'b0_0_0_1_0_0_0_0_0_0_0_01_00_00;
    localparam logic [16:0] C_DECODE = 17'b0_0_0_0_0_0_1_0_0_0_0_11_00_00;
    localparam logic [16:0] C_MEMADR = 17'b0_0_0_0_0_0_0_0_0_0_1_10_00_00;
    localparam logic [16:0] C_MEMRD  = 17'b0_0_1_1_0_0_0_0_0_0_0_00_00_00;
    localparam logic [16:0] C_MEMWB  = 17'b0_0_0_0_0_0_0_1_0_1_0_00_00_00;
    localparam logic [16:0] C_MEMWR  = 17'b0_0_1_0_1_0_0_0_0_0_0_00_00_00;
    localparam logic [16:0] C_EXEC   = 17'b0_0_0_0_0_0_0_0_0_0_1_00_10_00;
    localparam logic [16:0] C_ALUWB  = 17'b0_0_0_0_0_0_0_0_1_1_0_00_00_00;
    localparam logic [16:0] C_BRANCH = 17'b0_1_0_0_0_0_0_0_0_0_1_00_01_01;
    localparam logic [16:0] C_JUMP   = 17'b1_0_0_0_0_0_0_0_0_0_0_00_00_10;
    localparam logic [16:0] C_ADDIWB = 17'b0_0_0_0_0_0_0_0_0_1_0_00_00_00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        nvec++;
        if (got !== want) begin
            nmis++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
        end
    endtask

    // Current state and outputs, no clock advance.
    task automatic now(input string tag, input logic [3:0] st, input logic [16:0] c);
        chk({tag, ".state"}, {28'd0, state_dbg}, {28'd0, st});
        chk({tag, ".ctl"}, {15'd0, ctl}, {15'd0, c});
    endtask

    // Advance one clock, then check just after the edge.
    task automatic step(input string tag, input logic [3:0] st, input logic [16:0] c);
        @(posedge clk);
        #1;
        now(tag, st, c);
    endtask

    initial begin
        reset = 1'b1; opcode = 6'h00; mem_ready = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        now("rst", 4'd0, C_ZERO);
        chk("rst.ill", {31'd0, illegal_op}, 32'd0);
        reset = 1'b0;
        step("idle_to_fetch", 4'd1, C_FETCH);

        // Fetch stall: strobes drop combinationally, state holds.
        mem_ready = 1'b0; #1;
        now("fstall", 4'd1, C_FSTALL);
        step("fstall_hold", 4'd1, C_FSTALL);
        mem_ready = 1'b1; #1;
        now("fready", 4'd1, C_FETCH);

        // R-type: 1,2,7,8,1
        opcode = 6'h00;
        step("r.dec", 4'd2, C_DECODE);
        step("r.exec", 4'd7, C_EXEC);
        step("r.wb", 4'd8, C_ALUWB);
        step("r.fetch", 4'd1, C_FETCH);

        // LW with 3 stall cycles in MEMRD: 8 cycles total
        opcode = 6'h23;
        step("lw.dec", 4'd2, C_DECODE);
        mem_ready = 1'b0;
        step("lw.adr", 4'd3, C_MEMADR);
        step("lw.rd0", 4'd4, C_MEMRD);
        step("lw.rd1", 4'd4, C_MEMRD);
        step("lw.rd2", 4'd4, C_MEMRD);
        step("lw.rd3", 4'd4, C_MEMRD);
        mem_ready = 1'b1;
        step("lw.wb", 4'd5, C_MEMWB);
        step("lw.fetch", 4'd1, C_FETCH);

        // SW
        opcode = 6'h2B;
        step("sw.dec", 4'd2, C_DECODE);
        step("sw.adr", 4'd3, C_MEMADR);
        step("sw.wr", 4'd6, C_MEMWR);
        step("sw.fetch", 4'd1, C_FETCH);

        // BEQ
        opcode = 6'h04;
        step("beq.dec", 4'd2, C_DECODE);
        step("beq.br", 4'd9, C_BRANCH);
        step("beq.fetch", 4'd1, C_FETCH);

        // J
        opcode = 6'h02;
        step("j.dec", 4'd2, C_DECODE);
        step("j.jmp", 4'd10, C_JUMP);
        step("j.fetch", 4'd1, C_FETCH);
        chk("ill.clear", {31'd0, illegal_op}, 32'd0);

        // ADDI: legal only when the feature is built in
        opcode = 6'h08;
        step("addi.dec", 4'd2, C_DECODE);
`ifdef MULTICYCLE_CTRL_ADDI_EN
        step("addi.ex", 4'd11, C_MEMADR);
        step("addi.wb", 4'd12, C_ADDIWB);
        step("addi.fetch", 4'd1, C_FETCH);
        chk("addi.ill", {31'd0, illegal_op}, 32'd0);
`else
        step("addi.fetch", 4'd1, C_FETCH);
        chk("addi.ill", {31'd0, illegal_op}, 32'd1);
`endif

        // Undefined opcode: back to FETCH, sticky flag
        opcode = 6'h3F;
        step("bad.dec", 4'd2, C_DECODE);
        step("bad.fetch", 4'd1, C_FETCH);
        chk("bad.ill", {31'd0, illegal_op}, 32'd1);
        opcode = 6'h00;
        step("r2.dec", 4'd2, C_DECODE);
        step("r2.exec", 4'd7, C_EXEC);
        step("r2.wb", 4'd8, C_ALUWB);
        step("r2.fetch", 4'd1, C_FETCH);
        chk("ill.sticky", {31'd0, illegal_op}, 32'd1);

        // Reset mid-MEMRD: outputs clear asynchronously
        opcode = 6'h23;
        step("ab.dec", 4'd2, C_DECODE);
        mem_ready = 1'b0;
        step("ab.adr", 4'd3, C_MEMADR);
        step("ab.rd", 4'd4, C_MEMRD);
        #2 reset = 1'b1;
        #1;
        now("ab.async", 4'd0, C_ZERO);
        chk("ab.ill", {31'd0, illegal_op}, 32'd0);
        step("ab.hold", 4'd0, C_ZERO);
        reset = 1'b0; mem_ready = 1'b1;
        step("ab.fetch", 4'd1, C_FETCH);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the multicycle 32-bit MIPS-style datapath.
- Sequences the instruction register, the A/B operand registers, ALUOut, the PC, the register file and the shared instruction/data memory.
- Decodes the 6-bit opcode from the IR and drives every datapath enable and mux select.
- Waits on a memory-ready handshake so that slow memory stalls the datapath cleanly.

Parameters:
- OP_RTYPE, 6'h00, R-type opcode
- OP_LW, 6'h23, load-word opcode
- OP_SW, 6'h2B, store-word opcode
- OP_BEQ, 6'h04, branch-equal opcode
- OP_J, 6'h02, jump opcode

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- opcode  in  6  IR[31:26]
- mem_ready  in  1  memory has completed the current read/write this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load qualified by ALU zero (BEQ)
- i_or_d  out  1  memory address select: 0=PC, 1=ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load
- ab_write  out  1  load the A and B operand registers
- mem_to_reg  out  1  writeback select: 0=ALUOut, 1=MDR
- reg_dst  out  1  destination select: 0=rt, 1=rd
- reg_write  out  1  register file write
- alu_src_a  out  1  ALU A select: 0=PC, 1=A
- alu_src_b  out  2  ALU B select: 0=B, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2
- alu_op  out  2  0=add, 1=sub, 2=funct-decoded, 3=reserved
- pc_source  out  2  0=ALU result, 1=ALUOut, 2=jump target
- illegal_op  out  1  sticky flag: an undefined opcode was decoded
- state_dbg  out  4  current state encoding

Behaviour:
- Clock and reset:
  - Single clock, clk.
  - reset is asynchronous and active-high: it forces state=IDLE and illegal_op=0 immediately.
- Outputs:
  - All control outputs are decoded from the registered state, except the mem_ready-qualified strobes listed below.
  - In IDLE every output is 0.
  - Any output not listed for a state is 0.
- State sequence:
  - IDLE (0) -> FETCH unconditionally on the first clock after reset deasserts.
  - FETCH (1): mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_source=0. ir_write and pc_write assert only while mem_ready=1; the state holds in FETCH while mem_ready=0.
  - DECODE (2): ab_write=1, alu_src_a=0, alu_src_b=3, alu_op=0 (branch target into ALUOut). Next state is chosen by opcode: LW/SW -> MEMADR, RTYPE -> EXEC, BEQ -> BRANCH, J -> JUMP, any other opcode -> FETCH with illegal_op set to 1.
  - MEMADR (3): alu_src_a=1, alu_src_b=2, alu_op=0. Next: LW -> MEMRD, SW -> MEMWR.
  - MEMRD (4): mem_read=1, i_or_d=1. Holds until mem_ready=1, then -> MEMWB.
  - MEMWB (5): reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH.
  - MEMWR (6): mem_write=1, i_or_d=1. Holds until mem_ready=1, then -> FETCH.
  - EXEC (7): alu_src_a=1, alu_src_b=0, alu_op=2 -> ALUWB.
  - ALUWB (8): reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
  - BRANCH (9): alu_src_a=1, alu_src_b=0, alu_op=1, pc_write_cond=1, pc_source=1 -> FETCH.
  - JUMP (10): pc_write=1, pc_source=2 -> FETCH.
- Instruction latency with mem_ready always 1:
  - R-type 4 cycles, LW 5, SW 4, BEQ 3, J 3.
  - Each memory stall cycle adds 1.
- Boundary conditions:
  - mem_ready is ignored outside FETCH, MEMRD and MEMWR.
  - While stalled, all other outputs keep their state values and no register-write strobes fire.
  - Unused state encodings (11-15) -> FETCH on the next clock with all outputs 0.
  - illegal_op remains set until reset.
  - Reset asserted mid-instruction aborts it; outputs go to 0 asynchronously.

Optional Feature:
- Macro: MULTICYCLE_CTRL_ADDI_EN.
- Defined: opcode 6'h08 (ADDI) is legal. DECODE -> ADDIEX (11): alu_src_a=1, alu_src_b=2, alu_op=0 -> ADDIWB (12): reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH. Latency 4 cycles.
- Undefined: 6'h08 is treated as illegal; states 11/12 do not exist and are handled as unused encodings.

Test Plan:
- Reset then release with mem_ready=1 -> state_dbg 0 then 1. In FETCH: mem_read=1, ir_write=1, pc_write=1, alu_src_b=1.
- opcode=6'h00 with mem_ready=1 -> states 1,2,7,8,1. reg_write=1 and reg_dst=1 only in state 8; alu_op=2 in state 7.
- opcode=6'h23, mem_ready low for 3 cycles in MEMRD -> state 4 held for 4 cycles. MEMWB gives reg_write=1, mem_to_reg=1; total 8 cycles.
- opcode=6'h2B, then opcode=6'h04 -> SW: mem_write=1, i_or_d=1 in state 6. BEQ: pc_write_cond=1, alu_op=1, pc_source=1 in state 9.
- opcode=6'h3F -> DECODE returns to FETCH and illegal_op=1 stays high across later instructions until reset. With MULTICYCLE_CTRL_ADDI_EN defined, 6'h08 runs 1,2,11,12,1 and illegal_op stays 0.
- Assert reset while in state 4 -> all outputs 0 in the same cycle; state_dbg=0; FETCH resumes one clock after release.
